// File: rtl/sha256_miner_pkg.sv
// rtl/sha256_miner_pkg.sv - shared state type, widths and helpers for the SHA-256 nonce-scan miner
package sha256_miner_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } scan_state_t;

   localparam int NONCE_W    = 32;
   localparam int MIDSTATE_W = 256;
   localparam int DATA2_W    = 96;
   localparam int REM_W      = 33;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/golden_nonce_fifo.sv
// rtl/golden_nonce_fifo.sv - golden-nonce FIFO; head read straight from storage, pushes when full are dropped
module golden_nonce_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [PTR_W:0]   cnt_q;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == (PTR_W + 1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign pop_ok  = pop_i & !empty_o;
   // A full FIFO still accepts a push in the same cycle a pop frees a slot.
   assign push_ok = push_i & (!full_o | pop_ok);
   assign rdata_o = empty_o ? '0 : mem_q[rd_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + 1'b1;
         if (pop_ok)  rd_q <= rd_q + 1'b1;
         if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
         else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q] <= push_data_i;
   end

endmodule

// File: rtl/sha256_scan_ctrl.sv
// rtl/sha256_scan_ctrl.sv - nonce-scan controller broadcasting jobs to NUM_CORES SHA-256 lanes
// Define SCAN_STATS_EN to add the stat_nonces/stat_hits/stat_drops counter outputs.
module sha256_scan_ctrl
   import sha256_miner_pkg::*;
#(
   parameter int NUM_CORES  = 4,
   parameter int PIPE_LAT   = 64,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  job_valid,
   output logic                  job_ready,
   input  logic [MIDSTATE_W-1:0] job_midstate,
   input  logic [DATA2_W-1:0]    job_data2,
   input  logic [NONCE_W-1:0]    job_nonce_start,
   input  logic [NONCE_W-1:0]    job_nonce_count,
   output logic [MIDSTATE_W-1:0] core_midstate,
   output logic [DATA2_W-1:0]    core_data2,
   output logic [NONCE_W-1:0]    core_nonce_base,
   output logic [NUM_CORES-1:0]  core_lane_en,
   input  logic [NUM_CORES-1:0]  core_hit,
   output logic                  gn_valid,
   input  logic                  gn_ready,
   output logic [NONCE_W-1:0]    gn_nonce,
`ifdef SCAN_STATS_EN
   output logic [47:0]           stat_nonces,
   output logic [31:0]           stat_hits,
   output logic [15:0]           stat_drops,
`endif
   output logic                  miner_busy,
   output logic                  scan_done
);
   localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_LAT - 1);

   scan_state_t           state_q, state_d;
   logic [NONCE_W-1:0]    base_q, base_d;
   logic [REM_W-1:0]      rem_q, rem_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [MIDSTATE_W-1:0] mid_q, mid_d;
   logic [DATA2_W-1:0]    data2_q, data2_d;
   logic                  accept;
   logic [NUM_CORES-1:0]  lane_en;
   logic [NUM_CORES-1:0]  dl_en_q   [PIPE_LAT];
   logic [NONCE_W-1:0]    dl_base_q [PIPE_LAT];
   logic [NUM_CORES-1:0]  hit_vec;
   logic [NONCE_W-1:0]    sel_off;
   logic                  gn_push, gn_pop, fifo_full, fifo_empty;
   logic [NONCE_W-1:0]    gn_push_data;

   assign job_ready       = 1'b1;
   assign accept          = job_valid & job_ready;
   assign core_midstate   = mid_q;
   assign core_data2      = data2_q;
   assign core_nonce_base = base_q;
   assign core_lane_en    = lane_en;
   assign miner_busy      = (state_q != IDLE);

   always_comb begin
      lane_en = '0;
      if (state_q == SCAN)
         for (int i = 0; i < NUM_CORES; i++) lane_en[i] = (REM_W'(i) < rem_q);
   end

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      mid_d     = mid_q;
      data2_d   = data2_q;
      scan_done = 1'b0;
      if (accept) begin
         // Acceptance in SCAN/DRAIN aborts the current job silently.
         state_d = SCAN;
         base_d  = job_nonce_start;
         rem_d   = (job_nonce_count == '0) ? {1'b1, 32'h0} : {1'b0, job_nonce_count};
         cnt_d   = '0;
         mid_d   = job_midstate;
         data2_d = job_data2;
      end else begin
         case (state_q)
            SCAN: begin
               base_d = base_q + NONCE_W'(NUM_CORES);
               if (rem_q > REM_W'(NUM_CORES)) begin
                  rem_d = rem_q - REM_W'(NUM_CORES);
               end else begin
                  rem_d   = '0;
                  cnt_d   = '0;
                  state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (cnt_q == DRAIN_LAST) begin
                  scan_done = 1'b1;
                  state_d   = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         mid_q   <= '0;
         data2_q <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         mid_q   <= mid_d;
         data2_q <= data2_d;
      end
   end

   // Slot k holds the issue from k+1 cycles ago, so the last slot lines up with core_hit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            dl_en_q[i]   <= '0;
            dl_base_q[i] <= '0;
         end
      end else if (accept) begin
         for (int i = 0; i < PIPE_LAT; i++) dl_en_q[i] <= '0;
      end else begin
         dl_en_q[0]   <= lane_en;
         dl_base_q[0] <= base_q;
         for (int i = 1; i < PIPE_LAT; i++) begin
            dl_en_q[i]   <= dl_en_q[i-1];
            dl_base_q[i] <= dl_base_q[i-1];
         end
      end
   end

   assign hit_vec = core_hit & dl_en_q[PIPE_LAT-1] & {NUM_CORES{!accept}};

   always_comb begin
      sel_off = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--)
         if (hit_vec[i]) sel_off = NONCE_W'(i);
   end

   assign gn_push      = |hit_vec;
   assign gn_push_data = dl_base_q[PIPE_LAT-1] + sel_off;
   assign gn_valid     = !fifo_empty;
   assign gn_pop       = gn_valid & gn_ready;

   golden_nonce_fifo #(
      .WIDTH (NONCE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_gn_fifo (
      .clk_i       (clk),
      .rst_ni      (rst),
      .push_i      (gn_push),
      .push_data_i (gn_push_data),
      .pop_i       (gn_pop),
      .rdata_o     (gn_nonce),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

`ifdef SCAN_STATS_EN
   logic [4:0]  lane_cnt, hit_cnt;
   logic        fifo_drop;
   logic [16:0] drops_sum;
   logic [47:0] nonces_q;
   logic [31:0] hits_q;
   logic [15:0] drops_q;

   always_comb begin
      lane_cnt  = popcount16(16'(lane_en));
      hit_cnt   = popcount16(16'(hit_vec));
      fifo_drop = gn_push & fifo_full & !gn_pop;
      drops_sum = 17'(drops_q) + 17'(fifo_drop);
      if (gn_push) drops_sum = drops_sum + 17'(hit_cnt) - 17'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nonces_q <= '0;
         hits_q   <= '0;
         drops_q  <= '0;
      end else begin
         nonces_q <= nonces_q + 48'(lane_cnt);
         if (gn_push && !fifo_drop && hits_q != '1) hits_q <= hits_q + 32'd1;
         drops_q <= drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
      end
   end

   assign stat_nonces = nonces_q;
   assign stat_hits   = hits_q;
   assign stat_drops  = drops_q;
`else
   logic unused_fifo_full;
   assign unused_fifo_full = fifo_full;
`endif

endmodule

// File: tb/tb_sha256_scan_ctrl.sv
// tb/tb_sha256_scan_ctrl.sv - directed bench for sha256_scan_ctrl (NUM_CORES=4, PIPE_LAT=8, FIFO_DEPTH=4)
// Checks the SCAN_STATS_EN counters too when that macro is defined.
module tb_sha256_scan_ctrl;

   localparam logic [255:0] MID_C   = {8{32'hA5C3_0F17}};
   localparam logic [95:0]  DATA2_C = {3{32'h1234_5678}};

   logic         clk, rst;
   logic         job_valid, job_ready;
   logic [255:0] job_midstate, core_midstate;
   logic [95:0]  job_data2, core_data2;
   logic [31:0]  job_nonce_start, job_nonce_count, core_nonce_base, gn_nonce;
   logic [3:0]   core_lane_en, core_hit;
   logic         gn_valid, gn_ready, miner_busy, scan_done;
`ifdef SCAN_STATS_EN
   logic [47:0]  stat_nonces;
   logic [31:0]  stat_hits;
   logic [15:0]  stat_drops;
`endif

   sha256_scan_ctrl #(.NUM_CORES(4), .PIPE_LAT(8), .FIFO_DEPTH(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .job_valid       (job_valid),
      .job_ready       (job_ready),
      .job_midstate    (job_midstate),
      .job_data2       (job_data2),
      .job_nonce_start (job_nonce_start),
      .job_nonce_count (job_nonce_count),
      .core_midstate   (core_midstate),
      .core_data2      (core_data2),
      .core_nonce_base (core_nonce_base),
      .core_lane_en    (core_lane_en),
      .core_hit        (core_hit),
      .gn_valid        (gn_valid),
      .gn_ready        (gn_ready),
      .gn_nonce        (gn_nonce),
`ifdef SCAN_STATS_EN
      .stat_nonces     (stat_nonces),
      .stat_hits       (stat_hits),
      .stat_drops      (stat_drops),
`endif
      .miner_busy      (miner_busy),
      .scan_done       (scan_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        jv;
      logic [31:0] start;
      logic [31:0] count;
      logic [3:0]  hit;
      logic        rdy;
      logic        e_busy;
      logic [3:0]  e_lane;
      logic [31:0] e_base;
      logic        e_gv;
      logic [31:0] e_gn;
      logic        e_done;
   } vec_t;

   vec_t vecs [14];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic offer(input logic [31:0] s, input logic [31:0] n);
      job_valid       = 1'b1;
      job_nonce_start = s;
      job_nonce_count = n;
   endtask

   int          done_cnt, done_at;
   logic        gv_seen;
   logic [31:0] exp_q [4];

   initial begin
      // Partial last issue plus hit mapping, one row per cycle; accept at the end of row 0.
      vecs[0]  = '{1'b1, 32'h100, 32'd10, 4'h0, 1'b0, 1'b0, 4'h0, 32'h0,   1'b0, 32'h0,   1'b0};
      vecs[1]  = '{1'b0, 32'h0,   32'd0,  4'h0, 1'b0, 1'b1, 4'hF, 32'h100, 1'b0, 32'h0,   1'b0};
      vecs[2]  = '{1'b0, 32'h0,   32'd0,  4'h0, 1'b0, 1'b1, 4'hF, 32'h104, 1'b0, 32'h0,   1'b0};
      vecs[3]  = '{1'b0, 32'h0,   32'd0,  4'h0, 1'b0, 1'b1, 4'h3, 32'h108, 1'b0, 32'h0,   1'b0};
      for (int r = 4; r <= 9; r++)
         vecs[r] = '{1'b0, 32'h0, 32'd0, 4'h0, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0};
      vecs[10] = '{1'b0, 32'h0,   32'd0,  4'h4, 1'b0, 1'b1, 4'h0, 32'h0,   1'b0, 32'h0,   1'b0};
      vecs[11] = '{1'b0, 32'h0,   32'd0,  4'h8, 1'b0, 1'b1, 4'h0, 32'h0,   1'b1, 32'h106, 1'b1};
      vecs[12] = '{1'b0, 32'h0,   32'd0,  4'h0, 1'b1, 1'b0, 4'h0, 32'h0,   1'b1, 32'h106, 1'b0};
      vecs[13] = '{1'b0, 32'h0,   32'd0,  4'h0, 1'b0, 1'b0, 4'h0, 32'h0,   1'b0, 32'h0,   1'b0};

      rst = 1'b0;
      job_valid = 1'b0;
      job_midstate = MID_C;
      job_data2 = DATA2_C;
      job_nonce_start = '0;
      job_nonce_count = '0;
      core_hit = '0;
      gn_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst busy", 64'(miner_busy), 64'd0);
      check("rst job_ready", 64'(job_ready), 64'd1);
      check("rst lane_en", 64'(core_lane_en), 64'd0);
      check("rst gn_valid", 64'(gn_valid), 64'd0);
      check("rst scan_done", 64'(scan_done), 64'd0);
      check("rst midstate zero", 64'(core_midstate == '0), 64'd1);
      @(negedge clk);
      rst = 1'b1;

      for (int r = 0; r < 14; r++) begin
         @(negedge clk);
         job_valid = vecs[r].jv;
         job_nonce_start = vecs[r].start;
         job_nonce_count = vecs[r].count;
         core_hit = vecs[r].hit;
         gn_ready = vecs[r].rdy;
         #1;
         check($sformatf("row%0d busy", r), 64'(miner_busy), 64'(vecs[r].e_busy));
         check($sformatf("row%0d lane_en", r), 64'(core_lane_en), 64'(vecs[r].e_lane));
         if (vecs[r].e_lane != 4'h0)
            check($sformatf("row%0d base", r), 64'(core_nonce_base), 64'(vecs[r].e_base));
         check($sformatf("row%0d gn_valid", r), 64'(gn_valid), 64'(vecs[r].e_gv));
         if (vecs[r].e_gv)
            check($sformatf("row%0d gn_nonce", r), 64'(gn_nonce), 64'(vecs[r].e_gn));
         check($sformatf("row%0d scan_done", r), 64'(scan_done), 64'(vecs[r].e_done));
      end
      check("job midstate latched", 64'(core_midstate == MID_C), 64'd1);
      check("job data2 latched", 64'(core_data2 == DATA2_C), 64'd1);

      // Wrap: one issue at 0xFFFFFFFE, all four lanes hit.
      @(negedge clk);
      offer(32'hFFFF_FFFE, 32'd4);
      #1;
      @(negedge clk);
      job_valid = 1'b0;
      #1;
      check("wrap base", 64'(core_nonce_base), 64'hFFFF_FFFE);
      check("wrap lane_en", 64'(core_lane_en), 64'hF);
      repeat (7) @(negedge clk);
      @(negedge clk);
      core_hit = 4'hF;
      #1;
      check("wrap scan_done", 64'(scan_done), 64'd1);
      @(negedge clk);
      core_hit = 4'h0;
      gn_ready = 1'b1;
      #1;
      check("wrap gn_valid", 64'(gn_valid), 64'd1);
      check("wrap gn_nonce", 64'(gn_nonce), 64'hFFFF_FFFE);
      check("wrap idle", 64'(miner_busy), 64'd0);
      @(negedge clk);
      gn_ready = 1'b0;
      #1;
      check("wrap single push", 64'(gn_valid), 64'd0);
`ifdef SCAN_STATS_EN
      check("stat_nonces after wrap", 64'(stat_nonces), 64'd14);
      check("stat_hits after wrap", 64'(stat_hits), 64'd2);
      check("stat_drops after wrap", 64'(stat_drops), 64'd3);
`endif

      // Pre-emption two cycles into SCAN; old-job hit slots arrive at c9/c10.
      @(negedge clk);
      offer(32'h200, 32'd100);
      #1;
      @(negedge clk);
      job_valid = 1'b0;
      #1;
      check("pre old base0", 64'(core_nonce_base), 64'h200);
      @(negedge clk);
      offer(32'h500, 32'd8);
      #1;
      check("pre old base1", 64'(core_nonce_base), 64'h204);
      done_cnt = 0;
      done_at = 0;
      gv_seen = 1'b0;
      for (int c = 3; c <= 14; c++) begin
         @(negedge clk);
         job_valid = 1'b0;
         core_hit = (c == 9 || c == 10) ? 4'hF : 4'h0;
         #1;
         if (c == 3) begin
            check("pre new base0", 64'(core_nonce_base), 64'h500);
            check("pre new lane_en", 64'(core_lane_en), 64'hF);
         end
         if (c == 4) check("pre new base1", 64'(core_nonce_base), 64'h504);
         if (scan_done) begin
            done_cnt++;
            done_at = c;
         end
         if (gn_valid) gv_seen = 1'b1;
      end
      core_hit = 4'h0;
      check("pre scan_done count", 64'(done_cnt), 64'd1);
      check("pre scan_done cycle", 64'(done_at), 64'd12);
      check("pre no old push", 64'(gv_seen), 64'd0);
      check("pre idle", 64'(miner_busy), 64'd0);

      // FIFO full: five single lane-1 hits with the consumer stalled.
      @(negedge clk);
      offer(32'h1000, 32'd20);
      #1;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         job_valid = 1'b0;
         core_hit = (c >= 9) ? 4'h2 : 4'h0;
         #1;
      end
      @(negedge clk);
      core_hit = 4'h0;
      #1;
      check("full head held", 64'(gn_nonce), 64'h1001);
      check("full gn_valid", 64'(gn_valid), 64'd1);
      exp_q = '{32'h1001, 32'h1005, 32'h1009, 32'h100D};
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         gn_ready = 1'b1;
         #1;
         check($sformatf("full pop%0d valid", k), 64'(gn_valid), 64'd1);
         check($sformatf("full pop%0d nonce", k), 64'(gn_nonce), 64'(exp_q[k]));
      end
      @(negedge clk);
      gn_ready = 1'b0;
      #1;
      check("full 5th dropped", 64'(gn_valid), 64'd0);
`ifdef SCAN_STATS_EN
      check("stat_nonces after full", 64'(stat_nonces), 64'd50);
      check("stat_hits after full", 64'(stat_hits), 64'd6);
      check("stat_drops after full", 64'(stat_drops), 64'd4);
`endif

      // Asynchronous reset in the middle of SCAN with a nonce queued.
      @(negedge clk);
      offer(32'h40, 32'd1000);
      #1;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         job_valid = 1'b0;
         core_hit = (c == 9) ? 4'h1 : 4'h0;
         #1;
      end
      @(negedge clk);
      core_hit = 4'h0;
      #1;
      check("arst pre gn_valid", 64'(gn_valid), 64'd1);
      check("arst pre gn_nonce", 64'(gn_nonce), 64'h40);
      check("arst pre busy", 64'(miner_busy), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      check("arst busy", 64'(miner_busy), 64'd0);
      check("arst gn_valid", 64'(gn_valid), 64'd0);
      check("arst lane_en", 64'(core_lane_en), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("post rst job_ready", 64'(job_ready), 64'd1);
      check("post rst busy", 64'(miner_busy), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
